// File: rtl/execute_stage.sv
// execute_stage
//   Execute pipeline stage. Holds the decode/execute pipeline register,
//   applies operand forwarding, computes the ALU result and the destination
//   register for the memory stage, and runs an iterative shift-add
//   multiplier that fills the HI/LO product registers for mult/multu.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   stallE, flushE        hold / bubble the D/E register
//   *D                    decode-stage control, data and register fields
//   forwardAE, forwardBE  operand forward selects (00/11 reg, 01 W, 10 M)
//   resultW, aluoutM      forwarded values from writeback / memory
//   regwriteE, memwriteE, wbsrcE   registered control to the memory stage
//   aluoutE, writedataE, writeregE ALU result, store data, destination reg
//   rsE, rtE              source register fields to the hazard unit
//   pcplus4E              link value for jal
//   hiE, loE, multbusyE   product registers and multiplier busy flag
module execute_stage #(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        regwriteD,
  input  logic        memwriteD,
  input  logic        regdstD,
  input  logic        multstartD,
  input  logic        multsgnD,
  input  logic [2:0]  wbsrcD,
  input  logic [2:0]  alucontrolD,
  input  logic [1:0]  alusrcD,
  input  logic [31:0] rd1D,
  input  logic [31:0] rd2D,
  input  logic [31:0] signimmD,
  input  logic [31:0] unsignimmD,
  input  logic [31:0] pcplus4D,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  reD,
  input  logic [1:0]  forwardAE,
  input  logic [1:0]  forwardBE,
  input  logic [31:0] resultW,
  input  logic [31:0] aluoutM,
  output logic        regwriteE,
  output logic        memwriteE,
  output logic [2:0]  wbsrcE,
  output logic [31:0] aluoutE,
  output logic [31:0] writedataE,
  output logic [4:0]  writeregE,
  output logic [4:0]  rsE,
  output logic [4:0]  rtE,
  output logic [31:0] pcplus4E,
  output logic [31:0] hiE,
  output logic [31:0] loE,
  output logic        multbusyE
);

  localparam int unsigned CW = $clog2(MULT_CYCLES);
  localparam logic [CW-1:0] LAST_ITER = CW'(MULT_CYCLES - 1);

  typedef enum logic {IDLE, RUN} multState_t;

  // D/E register fields not exported directly
  logic        regdstE;
  logic        multstartE;
  logic        multsgnE;
  logic [2:0]  alucontrolE;
  logic [1:0]  alusrcE;
  logic [31:0] rd1E;
  logic [31:0] rd2E;
  logic [31:0] signimmE;
  logic [31:0] unsignimmE;
  logic [4:0]  reE;

  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] aluB;

  multState_t  multState;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [CW-1:0] iterCnt;
  logic        negResult;

  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        signRes;
  logic [63:0] accNext;
  logic [63:0] product;
  logic        startMult;

  // ---------------------------------------------------------------------
  // D/E pipeline register: flush beats stall
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwriteE   <= 1'b0;
      memwriteE   <= 1'b0;
      regdstE     <= 1'b0;
      multstartE  <= 1'b0;
      multsgnE    <= 1'b0;
      wbsrcE      <= '0;
      alucontrolE <= '0;
      alusrcE     <= '0;
      rd1E        <= '0;
      rd2E        <= '0;
      signimmE    <= '0;
      unsignimmE  <= '0;
      pcplus4E    <= '0;
      rsE         <= '0;
      rtE         <= '0;
      reE         <= '0;
    end else if (flushE) begin
      regwriteE   <= 1'b0;
      memwriteE   <= 1'b0;
      regdstE     <= 1'b0;
      multstartE  <= 1'b0;
      multsgnE    <= 1'b0;
      wbsrcE      <= '0;
      alucontrolE <= '0;
      alusrcE     <= '0;
      rd1E        <= '0;
      rd2E        <= '0;
      signimmE    <= '0;
      unsignimmE  <= '0;
      pcplus4E    <= '0;
      rsE         <= '0;
      rtE         <= '0;
      reE         <= '0;
    end else if (!stallE) begin
      regwriteE   <= regwriteD;
      memwriteE   <= memwriteD;
      regdstE     <= regdstD;
      multstartE  <= multstartD;
      multsgnE    <= multsgnD;
      wbsrcE      <= wbsrcD;
      alucontrolE <= alucontrolD;
      alusrcE     <= alusrcD;
      rd1E        <= rd1D;
      rd2E        <= rd2D;
      signimmE    <= signimmD;
      unsignimmE  <= unsignimmD;
      pcplus4E    <= pcplus4D;
      rsE         <= rsD;
      rtE         <= rtD;
      reE         <= reD;
    end
  end

  // ---------------------------------------------------------------------
  // Operand forwarding and operand-B source
  // ---------------------------------------------------------------------
  always_comb begin
    srcA = rd1E;
    case (forwardAE)
      2'b01:   srcA = resultW;
      2'b10:   srcA = aluoutM;
      default: srcA = rd1E;
    endcase
  end

  always_comb begin
    srcB = rd2E;
    case (forwardBE)
      2'b01:   srcB = resultW;
      2'b10:   srcB = aluoutM;
      default: srcB = rd2E;
    endcase
  end

  assign writedataE = srcB;

  always_comb begin
    aluB = srcB;
    case (alusrcE)
      2'b01:   aluB = signimmE;
      2'b10:   aluB = unsignimmE;
      default: aluB = srcB;
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------
  always_comb begin
    aluoutE = '0;
    case (alucontrolE)
      3'b000: aluoutE = srcA & aluB;
      3'b001: aluoutE = srcA | aluB;
      3'b010: aluoutE = srcA + aluB;
      3'b011: aluoutE = srcA ^ aluB;
      3'b100: aluoutE = ~(srcA ^ aluB);
      3'b101: aluoutE = srcA - aluB;
      3'b110: aluoutE = {31'b0, ($signed(srcA) < $signed(aluB))};
      3'b111: aluoutE = {aluB[15:0], 16'h0000};
      default: aluoutE = '0;
    endcase
  end

  // jal (wbsrc 000 with regwrite) always links into r31
  always_comb begin
    writeregE = regdstE ? reE : rtE;
    if (wbsrcE == 3'b000 && regwriteE)
      writeregE = 5'd31;
  end

  // ---------------------------------------------------------------------
  // Iterative multiplier
  // ---------------------------------------------------------------------
  // Signed operands are multiplied as magnitudes and the sign applied on
  // completion; -2^31 negates to itself, which is its correct unsigned
  // magnitude.
  assign magA      = srcA[31] ? (32'd0 - srcA) : srcA;
  assign magB      = srcB[31] ? (32'd0 - srcB) : srcB;
  assign opA       = multsgnE ? magA : srcA;
  assign opB       = multsgnE ? magB : srcB;
  assign signRes   = multsgnE & (srcA[31] ^ srcB[31]);
  assign startMult = multstartE & ~stallE;
  assign accNext   = acc + (mplier[0] ? mcand : 64'd0);
  assign product   = negResult ? (64'd0 - accNext) : accNext;

  // A start in RUN simply reloads the operands; HI/LO are only written on
  // the final iteration, so they keep the last completed product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      multState <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      iterCnt   <= '0;
      negResult <= 1'b0;
      hiE       <= '0;
      loE       <= '0;
      multbusyE <= 1'b0;
    end else if (startMult) begin
      multState <= RUN;
      mcand     <= {32'd0, opA};
      mplier    <= opB;
      acc       <= '0;
      iterCnt   <= '0;
      negResult <= signRes;
      multbusyE <= 1'b1;
    end else if (multState == RUN) begin
      acc     <= accNext;
      mcand   <= {mcand[62:0], 1'b0};
      mplier  <= {1'b0, mplier[31:1]};
      iterCnt <= iterCnt + 1'b1;
      if (iterCnt == LAST_ITER) begin
        {hiE, loE} <= product;
        multbusyE  <= 1'b0;
        multState  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
//   Directed-vector bench for execute_stage: pipeline register behaviour,
//   forwarding, ALU, destination selection and the iterative multiplier.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic        stallE, flushE;
  logic        regwriteD, memwriteD, regdstD, multstartD, multsgnD;
  logic [2:0]  wbsrcD, alucontrolD;
  logic [1:0]  alusrcD;
  logic [31:0] rd1D, rd2D, signimmD, unsignimmD, pcplus4D;
  logic [4:0]  rsD, rtD, reD;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] resultW, aluoutM;
  logic        regwriteE, memwriteE;
  logic [2:0]  wbsrcE;
  logic [31:0] aluoutE, writedataE;
  logic [4:0]  writeregE, rsE, rtE;
  logic [31:0] pcplus4E, hiE, loE;
  logic        multbusyE;

  int nChecks = 0;
  int nFail   = 0;
  int lat;
  logic [31:0] midHi, midLo;

  execute_stage #(.MULT_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
    .regwriteD(regwriteD), .memwriteD(memwriteD), .regdstD(regdstD),
    .multstartD(multstartD), .multsgnD(multsgnD), .wbsrcD(wbsrcD),
    .alucontrolD(alucontrolD), .alusrcD(alusrcD), .rd1D(rd1D), .rd2D(rd2D),
    .signimmD(signimmD), .unsignimmD(unsignimmD), .pcplus4D(pcplus4D),
    .rsD(rsD), .rtD(rtD), .reD(reD), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .resultW(resultW), .aluoutM(aluoutM),
    .regwriteE(regwriteE), .memwriteE(memwriteE), .wbsrcE(wbsrcE),
    .aluoutE(aluoutE), .writedataE(writedataE), .writeregE(writeregE),
    .rsE(rsE), .rtE(rtE), .pcplus4E(pcplus4E), .hiE(hiE), .loE(loE),
    .multbusyE(multbusyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearD();
    stallE = 0; flushE = 0;
    regwriteD = 0; memwriteD = 0; regdstD = 0; multstartD = 0; multsgnD = 0;
    wbsrcD = '0; alucontrolD = '0; alusrcD = '0;
    rd1D = '0; rd2D = '0; signimmD = '0; unsignimmD = '0; pcplus4D = '0;
    rsD = '0; rtD = '0; reD = '0;
    forwardAE = '0; forwardBE = '0; resultW = '0; aluoutM = '0;
  endtask

  // Issue a multiply, then wait (bounded) for completion. lat is the number
  // of edges after the start edge until multbusyE falls.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, output int latency);
    clearD();
    rd1D = a; rd2D = b; multstartD = 1; multsgnD = sgn;
    step();                // into D/E
    clearD();
    step();                // start edge
    latency = 0;
    while (multbusyE && latency < 40) begin
      step();
      latency++;
      if (latency == 5) begin
        midHi = hiE;
        midLo = loE;
      end
    end
  endtask

  task automatic test_reset();
    clearD();
    reset = 0;
    step(); step();
    nChecks++; if (regwriteE !== 1'b0) begin nFail++; $display("FAIL reset_regwrite got %h want 0", regwriteE); end
    nChecks++; if (aluoutE !== 32'h0) begin nFail++; $display("FAIL reset_aluout got %h want 0", aluoutE); end
    nChecks++; if (writeregE !== 5'd0) begin nFail++; $display("FAIL reset_writereg got %h want 0", writeregE); end
    nChecks++; if (hiE !== 32'h0 || loE !== 32'h0) begin nFail++; $display("FAIL reset_hilo got %h_%h want 0_0", hiE, loE); end
    nChecks++; if (multbusyE !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", multbusyE); end
    reset = 1;
    step();
  endtask

  task automatic test_alu_forward();
    clearD();
    rd1D = 7; rd2D = 5; alucontrolD = 3'b101; forwardAE = 2'b10; aluoutM = 20;
    step();
    nChecks++; if (aluoutE !== 32'd15) begin nFail++; $display("FAIL fwdA_sub got %h want %h", aluoutE, 32'd15); end
    forwardBE = 2'b01; resultW = 3;
    #1;
    nChecks++; if (aluoutE !== 32'd17) begin nFail++; $display("FAIL fwdB_sub got %h want %h", aluoutE, 32'd17); end
    nChecks++; if (writedataE !== 32'd3) begin nFail++; $display("FAIL fwdB_wdata got %h want 3", writedataE); end
    clearD();
    rd1D = 32'hFFFF_FFFF; rd2D = 1; alucontrolD = 3'b110;
    step();
    nChecks++; if (aluoutE !== 32'd1) begin nFail++; $display("FAIL slt_neg got %h want 1", aluoutE); end
    rd1D = 1; rd2D = 32'hFFFF_FFFF;
    step();
    nChecks++; if (aluoutE !== 32'd0) begin nFail++; $display("FAIL slt_pos got %h want 0", aluoutE); end
    rd1D = 32'hFFFF_FFFF; rd2D = 2; alucontrolD = 3'b010;
    step();
    nChecks++; if (aluoutE !== 32'd1) begin nFail++; $display("FAIL add_wrap got %h want 1", aluoutE); end
    rd1D = 32'h0F0F_0F0F; rd2D = 32'h00FF_00FF; alucontrolD = 3'b100;
    step();
    nChecks++; if (aluoutE !== 32'hF00F_F00F) begin nFail++; $display("FAIL xnor got %h want f00ff00f", aluoutE); end
    alucontrolD = 3'b011;
    step();
    nChecks++; if (aluoutE !== 32'h0FF0_0FF0) begin nFail++; $display("FAIL xor got %h want 0ff00ff0", aluoutE); end
  endtask

  task automatic test_immediates();
    clearD();
    rd1D = 32'hF000_0000; unsignimmD = 32'h0000_FFFF; alusrcD = 2'b10; alucontrolD = 3'b001;
    rd2D = 32'h1111_1111;
    step();
    nChecks++; if (aluoutE !== 32'hF000_FFFF) begin nFail++; $display("FAIL ori got %h want f000ffff", aluoutE); end
    nChecks++; if (writedataE !== 32'h1111_1111) begin nFail++; $display("FAIL imm_wdata got %h want 11111111", writedataE); end
    clearD();
    signimmD = 32'h0000_1234; alusrcD = 2'b01; alucontrolD = 3'b111;
    step();
    nChecks++; if (aluoutE !== 32'h1234_0000) begin nFail++; $display("FAIL lui got %h want 12340000", aluoutE); end
    clearD();
    rd1D = 10; signimmD = 32'hFFFF_FFFF; alusrcD = 2'b01; alucontrolD = 3'b010;
    step();
    nChecks++; if (aluoutE !== 32'd9) begin nFail++; $display("FAIL addi_neg got %h want 9", aluoutE); end
  endtask

  task automatic test_writereg();
    clearD();
    regwriteD = 1; regdstD = 1; rsD = 9; rtD = 3; reD = 7; wbsrcD = 3'b001;
    step();
    nChecks++; if (writeregE !== 5'd7) begin nFail++; $display("FAIL regdst_re got %0d want 7", writeregE); end
    nChecks++; if (rsE !== 5'd9 || rtE !== 5'd3) begin nFail++; $display("FAIL rs_rt got %0d/%0d want 9/3", rsE, rtE); end
    regdstD = 0;
    step();
    nChecks++; if (writeregE !== 5'd3) begin nFail++; $display("FAIL regdst_rt got %0d want 3", writeregE); end
    wbsrcD = 3'b000; pcplus4D = 32'h0000_0400;
    step();
    nChecks++; if (writeregE !== 5'd31) begin nFail++; $display("FAIL jal_r31 got %0d want 31", writeregE); end
    nChecks++; if (pcplus4E !== 32'h0000_0400) begin nFail++; $display("FAIL pcplus4 got %h want 00000400", pcplus4E); end
    regwriteD = 0;
    step();
    nChecks++; if (writeregE !== 5'd3) begin nFail++; $display("FAIL wb0_norw got %0d want 3", writeregE); end
  endtask

  task automatic test_flush_stall();
    clearD();
    regwriteD = 1; memwriteD = 1; rd1D = 7; rd2D = 5; alucontrolD = 3'b101;
    step();
    nChecks++; if (regwriteE !== 1'b1 || memwriteE !== 1'b1) begin nFail++; $display("FAIL load_ctrl got %b%b want 11", regwriteE, memwriteE); end
    nChecks++; if (aluoutE !== 32'd2) begin nFail++; $display("FAIL load_sub got %h want 2", aluoutE); end
    stallE = 1; flushE = 1;
    step();
    nChecks++; if (regwriteE !== 1'b0 || memwriteE !== 1'b0) begin nFail++; $display("FAIL flush_ctrl got %b%b want 00", regwriteE, memwriteE); end
    nChecks++; if (aluoutE !== 32'd0) begin nFail++; $display("FAIL flush_alu got %h want 0", aluoutE); end
    stallE = 0; flushE = 0;
    step();
    nChecks++; if (aluoutE !== 32'd2) begin nFail++; $display("FAIL reload_sub got %h want 2", aluoutE); end
    stallE = 1; rd1D = 100; regwriteD = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nChecks++; if (aluoutE !== 32'd2 || regwriteE !== 1'b1) begin nFail++; $display("FAIL stall_hold%0d got %h/%b want 2/1", i, aluoutE, regwriteE); end
    end
    stallE = 0;
    step();
    nChecks++; if (aluoutE !== 32'd95) begin nFail++; $display("FAIL stall_release got %h want %h", aluoutE, 32'd95); end
  endtask

  task automatic test_multu();
    midHi = 32'hDEAD_BEEF; midLo = 32'hDEAD_BEEF;
    do_mult(32'hFFFF_FFFF, 32'd2, 1'b0, lat);
    nChecks++; if (lat !== 32) begin nFail++; $display("FAIL multu_latency got %0d want 32", lat); end
    nChecks++; if (midHi !== 32'h0 || midLo !== 32'h0) begin nFail++; $display("FAIL multu_hilo_midrun got %h_%h want 0_0", midHi, midLo); end
    nChecks++; if (hiE !== 32'h0000_0001) begin nFail++; $display("FAIL multu_hi got %h want 00000001", hiE); end
    nChecks++; if (loE !== 32'hFFFF_FFFE) begin nFail++; $display("FAIL multu_lo got %h want fffffffe", loE); end
  endtask

  task automatic test_mult_signed();
    do_mult(32'hFFFF_FFFD, 32'd7, 1'b1, lat);
    nChecks++; if (lat !== 32) begin nFail++; $display("FAIL mult_latency got %0d want 32", lat); end
    nChecks++; if (hiE !== 32'hFFFF_FFFF || loE !== 32'hFFFF_FFEB) begin nFail++; $display("FAIL mult_m3x7 got %h_%h want ffffffff_ffffffeb", hiE, loE); end
    do_mult(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    nChecks++; if (lat !== 32) begin nFail++; $display("FAIL mult_min_latency got %0d want 32", lat); end
    nChecks++; if (hiE !== 32'h0 || loE !== 32'h8000_0000) begin nFail++; $display("FAIL mult_minxm1 got %h_%h want 00000000_80000000", hiE, loE); end
  endtask

  task automatic test_reset_midrun();
    clearD();
    rd1D = 5; rd2D = 9; multstartD = 1;
    step();
    clearD();
    step();
    for (int i = 0; i < 10; i++) step();
    nChecks++; if (multbusyE !== 1'b1) begin nFail++; $display("FAIL midrun_busy got %b want 1", multbusyE); end
    reset = 0;
    #1;
    nChecks++; if (multbusyE !== 1'b0) begin nFail++; $display("FAIL rst_mid_busy got %b want 0", multbusyE); end
    nChecks++; if (hiE !== 32'h0 || loE !== 32'h0) begin nFail++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", hiE, loE); end
    step();
    reset = 1;
    step();
    do_mult(32'd6, 32'd7, 1'b1, lat);
    nChecks++; if (lat !== 32) begin nFail++; $display("FAIL post_rst_latency got %0d want 32", lat); end
    nChecks++; if (hiE !== 32'h0 || loE !== 32'd42) begin nFail++; $display("FAIL post_rst_6x7 got %h_%h want 00000000_0000002a", hiE, loE); end
  endtask

  initial begin
    reset = 0;
    clearD();
    test_reset();
    test_alu_forward();
    test_immediates();
    test_writereg();
    test_flush_stall();
    test_multu();
    test_mult_signed();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
